// File: rtl/axi_cmd_mm2s.sv
// -----------------------------------------------------------------------------
// axi_cmd_mm2s
// Command-driven memory-to-stream mover. A command (tag, address, EOF, byte
// count) is accepted on the command stream, turned into one or more AXI4 INCR
// read bursts of 32-bit beats that never cross a 4 KB page, and the returned
// read data is passed straight through to the output stream. When all bytes
// have been moved (or the command was rejected), one status byte is emitted.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   S_AXIS_CMD_*            command stream: [67:64] tag, [63:32] address,
//                           [30] EOF, [22:0] bytes to transfer
//   M_AXIS_STS_*            status stream: {OKAY, SLVERR, DECERR, INTERR, tag}
//   M_AXI_AR*               AXI read address channel (one burst at a time)
//   M_AXI_R*                AXI read data channel (RLAST is not used)
//   M_AXIS_*                output data stream, zero-latency pass-through of R
// -----------------------------------------------------------------------------
module axi_cmd_mm2s #(
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_S_AXIS_CMD_DATA_WIDTH = 73,
  parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
  parameter int C_MAX_BURST_LEN         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // command stream
  input  logic                               S_AXIS_CMD_TVALID,
  output logic                               S_AXIS_CMD_TREADY,
  input  logic [C_S_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA,
  // status stream
  output logic                               M_AXIS_STS_TVALID,
  input  logic                               M_AXIS_STS_TREADY,
  output logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA,
  // AXI read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  // AXI read data channel
  input  logic [31:0]                        M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY,
  // output data stream
  output logic [31:0]                        M_AXIS_TDATA,
  output logic                               M_AXIS_TVALID,
  output logic                               M_AXIS_TLAST,
  input  logic                               M_AXIS_TREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_STS
  } state_t;

  state_t                          r_state;
  logic                            r_cmd_ready;
  logic [3:0]                      r_tag;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic                            r_eof;
  logic [22:0]                     r_remaining;
  logic [7:0]                      r_arlen;
  logic                            r_arvalid;
  logic [7:0]                      r_beat_cnt;
  logic                            r_slverr;
  logic                            r_decerr;
  logic                            r_interr;
  logic                            r_sts_valid;

  // Beats in the next burst: limited by the burst cap, by the bytes still to
  // move and by the distance to the end of the current 4 KB page.
  function automatic logic [4:0] f_beats(input logic [11:0] page_off,
                                         input logic [20:0] rem_beats);
    logic [10:0] page_beats;
    logic [4:0]  n;
    page_beats = 11'((13'd4096 - {1'b0, page_off}) >> 2);
    n = 5'(C_MAX_BURST_LEN);
    if (rem_beats < 21'(n))  n = 5'(rem_beats);
    if (page_beats < 11'(n)) n = 5'(page_beats);
    return n;
  endfunction

  // command field extraction
  logic [3:0]                    w_cmd_tag;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_cmd_addr;
  logic                          w_cmd_eof;
  logic [22:0]                   w_cmd_btt;
  logic                          w_cmd_bad;

  assign w_cmd_tag  = S_AXIS_CMD_TDATA[67:64];
  assign w_cmd_addr = C_M_AXI_ADDR_WIDTH'(S_AXIS_CMD_TDATA[63:32]);
  assign w_cmd_eof  = S_AXIS_CMD_TDATA[30];
  assign w_cmd_btt  = S_AXIS_CMD_TDATA[22:0];
  // Only whole, word-aligned, non-empty transfers are supported.
  assign w_cmd_bad  = (w_cmd_btt == 23'd0) || (w_cmd_btt[1:0] != 2'b00) ||
                      (w_cmd_addr[1:0] != 2'b00);

  logic w_unused_bits;
  assign w_unused_bits = ^{S_AXIS_CMD_TDATA[C_S_AXIS_CMD_DATA_WIDTH-1:68],
                           S_AXIS_CMD_TDATA[31], S_AXIS_CMD_TDATA[29:23],
                           M_AXI_RLAST};

  // current burst bookkeeping
  logic                          w_in_data;
  logic                          w_beat;
  logic [4:0]                    w_beats;
  logic [22:0]                   w_burst_bytes;
  logic                          w_last_beat;
  logic                          w_final_burst;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [22:0]                   w_next_rem;

  assign w_in_data     = (r_state == S_DATA);
  assign w_beat        = w_in_data && M_AXI_RVALID && M_AXIS_TREADY;
  assign w_beats       = r_arlen[4:0] + 5'd1;
  assign w_burst_bytes = 23'({w_beats, 2'b00});
  // The beat count comes from our own counter; RLAST is not trusted.
  assign w_last_beat   = (r_beat_cnt == r_arlen);
  assign w_final_burst = (r_remaining == w_burst_bytes);
  assign w_next_addr   = r_addr + C_M_AXI_ADDR_WIDTH'(w_burst_bytes);
  assign w_next_rem    = r_remaining - w_burst_bytes;

  // NOTE: the R -> M_AXIS path is purely combinational but gated by the
  // registered state, so every stream output is 0 outside DATA and in reset.
  assign M_AXIS_TDATA  = w_in_data ? M_AXI_RDATA : 32'd0;
  assign M_AXIS_TVALID = w_in_data && M_AXI_RVALID;
  assign M_AXI_RREADY  = w_in_data && M_AXIS_TREADY;
  assign M_AXIS_TLAST  = w_in_data && r_eof && w_last_beat && w_final_burst;

  assign S_AXIS_CMD_TREADY = r_cmd_ready;
  assign M_AXI_ARADDR      = r_addr;
  assign M_AXI_ARLEN       = r_arlen;
  assign M_AXI_ARSIZE      = 3'b010;
  assign M_AXI_ARBURST     = 2'b01;
  assign M_AXI_ARVALID     = r_arvalid;
  assign M_AXIS_STS_TVALID = r_sts_valid;

  logic [7:0] w_sts;
  assign w_sts = r_sts_valid
               ? {!(r_slverr || r_decerr || r_interr), r_slverr, r_decerr,
                  r_interr, r_tag}
               : 8'd0;
  assign M_AXIS_STS_TDATA = C_M_AXIS_STS_DATA_WIDTH'(w_sts);

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_tag       <= '0;
      r_addr      <= '0;
      r_eof       <= 1'b0;
      r_remaining <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_beat_cnt  <= '0;
      r_slverr    <= 1'b0;
      r_decerr    <= 1'b0;
      r_interr    <= 1'b0;
      r_sts_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Ready comes up one edge after reset release and stays up in IDLE.
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && S_AXIS_CMD_TVALID) begin
            r_cmd_ready <= 1'b0;
            r_tag       <= w_cmd_tag;
            r_addr      <= w_cmd_addr;
            r_eof       <= w_cmd_eof;
            r_remaining <= w_cmd_btt;
            r_beat_cnt  <= '0;
            if (w_cmd_bad) begin
              r_interr    <= 1'b1;
              r_sts_valid <= 1'b1;
              r_state     <= S_STS;
            end else begin
              r_arlen   <= 8'(f_beats(w_cmd_addr[11:0], w_cmd_btt[22:2]) - 5'd1);
              r_arvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_beat) begin
            if (M_AXI_RRESP == 2'b10) r_slverr <= 1'b1;
            if (M_AXI_RRESP == 2'b11) r_decerr <= 1'b1;
            if (w_last_beat) begin
              r_addr      <= w_next_addr;
              r_remaining <= w_next_rem;
              r_beat_cnt  <= '0;
              if (w_final_burst) begin
                r_sts_valid <= 1'b1;
                r_state     <= S_STS;
              end else begin
                r_arlen   <= 8'(f_beats(w_next_addr[11:0], w_next_rem[22:2]) - 5'd1);
                r_arvalid <= 1'b1;
                r_state   <= S_ADDR;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end

        S_STS: begin
          if (M_AXIS_STS_TREADY) begin
            r_sts_valid <= 1'b0;
            r_slverr    <= 1'b0;
            r_decerr    <= 1'b0;
            r_interr    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cmd_mm2s.sv
// -----------------------------------------------------------------------------
// tb_axi_cmd_mm2s
// Self-checking bench for axi_cmd_mm2s. The bench plays AXI read slave, output
// stream sink and status sink with random stalls. Expected bursts and status
// are derived from each command with plain integer arithmetic; expected data
// is the sequence the slave actually returned.
// -----------------------------------------------------------------------------
module tb_axi_cmd_mm2s;

  localparam int MAXB   = 16;
  localparam int BUDGET = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        S_AXIS_CMD_TVALID = 1'b0;
  logic        S_AXIS_CMD_TREADY;
  logic [72:0] S_AXIS_CMD_TDATA = '0;
  logic        M_AXIS_STS_TVALID;
  logic        M_AXIS_STS_TREADY = 1'b0;
  logic [7:0]  M_AXIS_STS_TDATA;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b0;

  always #5 clk = ~clk;

  axi_cmd_mm2s #(
    .C_M_AXI_ADDR_WIDTH      (32),
    .C_S_AXIS_CMD_DATA_WIDTH (73),
    .C_M_AXIS_STS_DATA_WIDTH (8),
    .C_MAX_BURST_LEN         (MAXB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
    .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
    .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
    .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
    .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
    .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
    .M_AXI_ARADDR      (M_AXI_ARADDR),
    .M_AXI_ARLEN       (M_AXI_ARLEN),
    .M_AXI_ARSIZE      (M_AXI_ARSIZE),
    .M_AXI_ARBURST     (M_AXI_ARBURST),
    .M_AXI_ARVALID     (M_AXI_ARVALID),
    .M_AXI_ARREADY     (M_AXI_ARREADY),
    .M_AXI_RDATA       (M_AXI_RDATA),
    .M_AXI_RRESP       (M_AXI_RRESP),
    .M_AXI_RLAST       (M_AXI_RLAST),
    .M_AXI_RVALID      (M_AXI_RVALID),
    .M_AXI_RREADY      (M_AXI_RREADY),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TLAST      (M_AXIS_TLAST),
    .M_AXIS_TREADY     (M_AXIS_TREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dq[$];          // data presented by the slave, not yet seen
  logic [31:0] exp_araddr[$];  // expected bursts of the current command
  int          exp_arlen[$];
  int          g_beat_idx;     // beat index within the current command
  int          g_err_idx;      // beat that gets an error response (-1 none)
  logic [1:0]  g_err_resp;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: split a command into bursts (beats <= MAXB, <= bytes left,
  // never past the end of a 4 KB page; address wraps at 2^32).
  task automatic plan_bursts(input logic [31:0] addr, input int btt);
    logic [31:0] a;
    int r, n, pg;
    exp_araddr.delete();
    exp_arlen.delete();
    a = addr;
    r = btt;
    while (r > 0) begin
      n  = r / 4;
      pg = (4096 - int'(a[11:0])) / 4;
      if (n > MAXB) n = MAXB;
      if (n > pg)   n = pg;
      exp_araddr.push_back(a);
      exp_arlen.push_back(n - 1);
      a = a + 32'(4 * n);
      r = r - 4 * n;
    end
  endtask

  task automatic send_cmd(input logic [31:0] addr, input int btt,
                          input logic [3:0] tag, input logic eof);
    logic [72:0] c;
    bit hs;
    int t;
    c = '0;
    c[72:68] = 5'($urandom);     // ignored bits carry noise
    c[31]    = 1'($urandom);
    c[29:23] = 7'($urandom);
    c[67:64] = tag;
    c[63:32] = addr;
    c[30]    = eof;
    c[22:0]  = 23'(btt);
    @(negedge clk);
    S_AXIS_CMD_TDATA  = c;
    S_AXIS_CMD_TVALID = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < BUDGET) begin
      #1 hs = S_AXIS_CMD_TREADY;
      @(negedge clk);
      t++;
    end
    S_AXIS_CMD_TVALID = 1'b0;
    check("cmd_accept", 64'(hs), 64'd1);
  endtask

  task automatic ar_phase(input logic [31:0] a, input int len);
    int t = 0;
    while (!M_AXI_ARVALID && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    check("ar_valid", 64'(M_AXI_ARVALID), 64'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("ar_hold", 64'(M_AXI_ARVALID), 64'd1);
    M_AXI_ARREADY = 1'b1;
    #1;
    check("araddr", 64'(M_AXI_ARADDR), 64'(a));
    check("arlen", 64'(M_AXI_ARLEN), 64'(len));
    check("arsize_burst", 64'({M_AXI_ARSIZE, M_AXI_ARBURST}), 64'({3'b010, 2'b01}));
    @(negedge clk);
    M_AXI_ARREADY = 1'b0;
  endtask

  task automatic r_phase(input int nbeats);
    int  sent = 0;
    int  t = 0;
    bit  pending = 1'b0;
    logic [31:0] d;
    while (sent < nbeats && t < BUDGET) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          d = $urandom;
          M_AXI_RDATA  = d;
          M_AXI_RRESP  = (g_beat_idx == g_err_idx) ? g_err_resp : 2'b00;
          M_AXI_RLAST  = (sent == nbeats - 1);
          M_AXI_RVALID = 1'b1;
          dq.push_back(d);
          pending = 1'b1;
        end else begin
          M_AXI_RVALID = 1'b0;
        end
      end
      #1;
      if (pending && M_AXI_RREADY) begin
        pending = 1'b0;
        sent++;
        g_beat_idx++;
      end
      @(negedge clk);
      t++;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    check("r_beats_taken", 64'(sent), 64'(nbeats));
  endtask

  task automatic slave();
    while (exp_araddr.size() > 0) begin
      logic [31:0] a;
      int len;
      a   = exp_araddr.pop_front();
      len = exp_arlen.pop_front();
      ar_phase(a, len);
      r_phase(len + 1);
    end
  endtask

  task automatic sink(input int total, input logic eof);
    int got = 0;
    int t = 0;
    logic [31:0] e;
    while (got < total && t < BUDGET) begin
      M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      #1;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        check("beat_expected", 64'(dq.size() != 0), 64'd1);
        e = (dq.size() != 0) ? dq.pop_front() : 32'd0;
        check("tdata", 64'(M_AXIS_TDATA), 64'(e));
        check("tlast", 64'(M_AXIS_TLAST), 64'(eof && (got == total - 1)));
        got++;
      end
      @(negedge clk);
      t++;
    end
    M_AXIS_TREADY = 1'b0;
    check("beats_out", 64'(got), 64'(total));
  endtask

  task automatic status(input logic [7:0] exp, input bit no_traffic);
    int t = 0;
    bit seen = 1'b0;
    while (!M_AXIS_STS_TVALID && t < BUDGET) begin
      seen |= M_AXI_ARVALID | M_AXIS_TVALID;
      @(negedge clk);
      t++;
    end
    check("sts_valid", 64'(M_AXIS_STS_TVALID), 64'd1);
    if (no_traffic) check("no_axi_traffic", 64'(seen), 64'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("sts_hold", 64'(M_AXIS_STS_TDATA), 64'(exp));
    M_AXIS_STS_TREADY = 1'b1;
    #1 check("sts_data", 64'(M_AXIS_STS_TDATA), 64'(exp));
    @(negedge clk);
    M_AXIS_STS_TREADY = 1'b0;
    check("sts_drop_ready_up", 64'({M_AXIS_STS_TVALID, S_AXIS_CMD_TREADY}), 64'b01);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int btt,
                         input logic [3:0] tag, input logic eof,
                         input int err_idx, input logic [1:0] err_resp);
    bit bad, slv, dec;
    logic [7:0] exp;
    bad = (btt == 0) || (btt % 4 != 0) || (addr[1:0] != 2'b00);
    slv = !bad && err_idx >= 0 && err_idx < btt / 4 && err_resp == 2'b10;
    dec = !bad && err_idx >= 0 && err_idx < btt / 4 && err_resp == 2'b11;
    exp = {!(bad || slv || dec), slv, dec, bad, tag};
    g_beat_idx = 0;
    g_err_idx  = err_idx;
    g_err_resp = err_resp;
    dq.delete();
    if (bad) begin
      exp_araddr.delete();
      exp_arlen.delete();
    end else begin
      plan_bursts(addr, btt);
    end
    send_cmd(addr, btt, tag, eof);
    if (!bad) begin
      fork
        slave();
        sink(btt / 4, eof);
      join
      check("no_extra_data", 64'(dq.size()), 64'd0);
    end
    status(exp, bad);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({S_AXIS_CMD_TREADY, M_AXIS_STS_TVALID, M_AXI_ARVALID,
                    M_AXIS_TVALID, M_AXIS_TLAST, M_AXI_RREADY}), 64'd0);
    check({tag, "_data"}, {M_AXIS_TDATA, M_AXI_ARADDR}, 64'd0);
    check({tag, "_len_sts"}, 64'({M_AXI_ARLEN, M_AXIS_STS_TDATA}), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    int btt;

    // power-on reset
    #1 check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(S_AXIS_CMD_TREADY), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(S_AXIS_CMD_TREADY), 64'd1);

    // directed cases
    run_cmd(32'h1000_0000, 64, 4'd3, 1'b1, -1, 2'b00);   // 1 burst, 0x83
    run_cmd(32'h0000_0FF0, 32, 4'd5, 1'b0, -1, 2'b00);   // page split, 0x85
    run_cmd(32'h0000_0FF8, 16, 4'd2, 1'b1, -1, 2'b00);   // 2 + 2 beats
    run_cmd(32'hFFFF_FFF0, 32, 4'd4, 1'b1, -1, 2'b00);   // address wraps
    run_cmd(32'h0000_0100, 6,  4'd1, 1'b1, -1, 2'b00);   // odd size, 0x11
    run_cmd(32'h0000_0100, 0,  4'd1, 1'b1, -1, 2'b00);   // empty, 0x11
    run_cmd(32'h0000_0102, 8,  4'd7, 1'b0, -1, 2'b00);   // misaligned, 0x17
    run_cmd(32'h3000_0000, 16, 4'd9, 1'b1, 1, 2'b10);    // SLVERR, 0x49
    run_cmd(32'h3000_0040, 16, 4'd9, 1'b1, -1, 2'b00);   // flags cleared
    run_cmd(32'h3000_0080, 40, 4'hA, 1'b0, 9, 2'b11);    // DECERR on last beat
    run_cmd(32'h4000_0F00, 400, 4'd6, 1'b1, -1, 2'b00);  // 100 beats, stalls

    // random commands, biased toward page ends and occasional rejects
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) != 0)
        a = ($urandom & 32'hFFFF_F000) | 32'(12'hFFC - 12'(4 * $urandom_range(0, 24)));
      else
        a = $urandom & 32'hFFFF_FFFC;
      btt = 4 * $urandom_range(1, 48);
      if ($urandom_range(0, 6) == 0) btt = btt + 2;
      if ($urandom_range(0, 9) == 0) a = a | 32'd1;
      run_cmd(a, btt, 4'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(0, 12)) : -1,
              2'($urandom_range(2, 3)));
    end

    // reset in the middle of a 64-byte transfer
    g_beat_idx = 0;
    g_err_idx  = -1;
    send_cmd(32'h2000_0000, 64, 4'd7, 1'b1);
    ar_phase(32'h2000_0000, 15);
    M_AXI_RVALID  = 1'b1;
    M_AXI_RDATA   = 32'hDEAD_BEEF;
    M_AXIS_TREADY = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    M_AXI_RVALID  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    M_AXIS_STS_TREADY = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge2", 64'(S_AXIS_CMD_TREADY), 64'd0);
    repeat (4) @(negedge clk);
    check("no_sts_after_reset", 64'({M_AXIS_STS_TVALID, M_AXI_ARVALID, S_AXIS_CMD_TREADY}), 64'b001);
    M_AXIS_STS_TREADY = 1'b0;
    run_cmd(32'h2000_0000, 64, 4'd8, 1'b1, -1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
